alu_writeback88: RTL
====================

Name: alu_writeback88

Overview:
- Execute/writeback stage directly downstream of the core88 operand-fetch (FETCHEA) stage.
- Takes the decoded ALU group (opcodes 00_xxx_0xx) with fetched op1/op2, modrm, size/direction and EA.
- Computes the 8/16-bit ALU result and flags, then writes the result to the register file or to memory over the 8-bit bus.
- A 16-bit memory store takes two byte cycles.

Parameters:
- FLAGS_W, 16, width of flags word (CF=0, PF=2, AF=4, ZF=6, SF=7, OF=11; other bits pass through).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- locked  in  1  clock enable; when 0 all state and outputs hold
- start  in  1  one-cycle request; latches all operand inputs
- alumode  in  3  0 ADD, 1 OR, 2 ADC, 3 SBB, 4 AND, 5 SUB, 6 XOR, 7 CMP
- isize  in  1  1 = 16-bit, 0 = 8-bit
- idir  in  1  1 = destination is reg field, 0 = destination is r/m
- modrm  in  8  modrm byte
- op1  in  16  destination operand (left side)
- op2  in  16  source operand
- flags_in  in  FLAGS_W  current flags (CF used by ADC/SBB)
- seg  in  16  effective segment
- ea  in  16  effective offset
- busy  out  1  stage occupied
- done  out  1  one-cycle pulse, instruction retired
- flags_out  out  FLAGS_W  updated flags, valid from CALC+1 and held
- reg_we  out  1  register write strobe (1 cycle)
- reg_num  out  3  register index (modrm encoding)
- reg_size  out  1  1 = word write; 0 = byte (4..7 = AH,CH,DH,BH)
- reg_data  out  16  write data (byte in [7:0], [15:8]=0 when byte)
- bus_sel  out  1  1 while this block owns the address mux
- address  out  20  {seg,4'h0} + ea_cur, modulo 2^20
- data  out  8  write byte
- wreq  out  1  memory write request

Behaviour:
- Reset (async):
  - state = IDLE.
  - busy, done, reg_we, wreq and bus_sel = 0.
  - data = 0, reg_data = 0, flags_out = 0, address = 0.
- FSM states: IDLE, CALC, WRLO, WRHI.
- IDLE:
  - start=1 latches all inputs and goes to CALC; busy=1 from the next cycle.
  - start while busy is ignored.
- CALC (1 cycle): result = op1 op op2 (+CF for ADC, -CF for SBB); flags_out updated.
  - CMP: no write. done=1 on the next cycle, then IDLE.
  - modrm[7:6]==3 or idir=1: destination is a register.
    - reg_num = idir ? modrm[5:3] : modrm[2:0].
    - reg_we=1 for one cycle together with done; then IDLE.
  - Otherwise: go to WRLO.
- WRLO:
  - bus_sel=1, wreq=1, address = seg*16+ea, data = res[7:0].
  - isize=0: done=1 here, then IDLE.
  - isize=1: go to WRHI.
- WRHI:
  - address = seg*16 + ((ea+1) mod 2^16), data = res[15:8], wreq=1.
  - done=1 here, then IDLE.
- Latency from start: register or CMP = 2 cycles to done; memory byte = 2; memory word = 3.
- Flags, width W = 8 or 16:
  - CF: carry out of bit W-1 (add) or borrow (sub/cmp/sbb).
  - AF: carry/borrow from bit 3.
  - OF: signed overflow.
  - SF: res[W-1].
  - ZF: res[W-1:0]==0.
  - PF: even parity of res[7:0] (both sizes).
  - OR/AND/XOR: CF=OF=AF=0.
- Outside active cycles: wreq, reg_we and done are 0; bus_sel is 0 outside WRLO/WRHI.
- locked=0 freezes the FSM mid-transfer: address, data and wreq stay stable.
- Reset mid-operation aborts immediately. A WRHI cut by reset is not completed.

Test Plan:
- ADD byte, modrm=C1, idir=0, op1=7F, op2=01:
  - reg_we, reg_num=1, reg_size=0, reg_data=0080.
  - OF=1, SF=1, AF=1, ZF=0, CF=0, PF=0.
  - done at start+2.
- SUB word to memory, modrm=07, idir=0, seg=1000, ea=FFFF, op1=0000, op2=0001:
  - WRLO addr 1FFFF data FF; WRHI addr 10000 data FF (ea wraps).
  - CF=1, SF=1, ZF=0.
  - done at start+3.
- CMP word, op1=op2=1234: no wreq, no reg_we; ZF=1, CF=0, PF=1; done at start+2.
- ADC word reg, CF_in=1, op1=FFFF, op2=0000: reg_data=0000, CF=1, ZF=1, AF=1, PF=1, OF=0.
- locked=0 held 3 cycles during WRLO:
  - address, data and wreq stable; WRHI follows once locked=1.
  - Assert reset during WRHI: wreq=0, busy=0 immediately.
- start pulsed again while busy: ignored, single result written.
- Next start after done is accepted.

Source files
------------

// File: rtl/alu_writeback88.sv
// ALU execute/writeback for the 00_xxx_0xx group: result to register file or 8-bit memory bus.
// Done 2 cycles after start (reg/CMP/byte store) or 3 (word store); locked=0 freezes all state; start ignored while busy.
module alu_writeback88 #(
    parameter int FLAGS_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               locked,
    input  logic               start,
    input  logic [2:0]         alumode,
    input  logic               isize,
    input  logic               idir,
    input  logic [7:0]         modrm,
    input  logic [15:0]        op1,
    input  logic [15:0]        op2,
    input  logic [FLAGS_W-1:0] flags_in,
    input  logic [15:0]        seg,
    input  logic [15:0]        ea,
    output logic               busy,
    output logic               done,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               reg_we,
    output logic [2:0]         reg_num,
    output logic               reg_size,
    output logic [15:0]        reg_data,
    output logic               bus_sel,
    output logic [19:0]        address,
    output logic [7:0]         data,
    output logic               wreq
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] WRLO = 2'd2;
    localparam logic [1:0] WRHI = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0, OP_OR  = 3'd1, OP_ADC = 3'd2, OP_SBB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4, OP_SUB = 3'd5, OP_XOR = 3'd6, OP_CMP = 3'd7;

    logic [1:0]         r_state;
    logic               r_busy, r_done, r_reg_we, r_bus_sel, r_wreq, r_reg_size;
    logic [2:0]         r_mode, r_reg_num;
    logic               r_size, r_dir;
    logic [7:0]         r_modrm, r_data;
    logic [15:0]        r_op1, r_op2, r_seg, r_ea, r_res, r_reg_data;
    logic [FLAGS_W-1:0] r_flags_in, r_flags;
    logic [19:0]        r_address;

    logic               w_cin, w_is_sub, w_is_logic, w_to_reg;
    logic               w_a_msb, w_b_msb, w_r_msb;
    logic [16:0]        w_arith;
    logic [15:0]        w_res, w_res_sz, w_ea_inc;
    logic [19:0]        w_addr_lo, w_addr_hi;
    logic [FLAGS_W-1:0] w_flags;

    assign w_cin      = ((r_mode == OP_ADC) || (r_mode == OP_SBB)) ? r_flags_in[0] : 1'b0;
    assign w_is_sub   = (r_mode == OP_SUB) || (r_mode == OP_SBB) || (r_mode == OP_CMP);
    assign w_is_logic = (r_mode == OP_OR) || (r_mode == OP_AND) || (r_mode == OP_XOR);
    assign w_to_reg   = (r_modrm[7:6] == 2'b11) || r_dir;
    assign w_arith    = w_is_sub ? ({1'b0, r_op1} - {1'b0, r_op2} - {16'b0, w_cin})
                                 : ({1'b0, r_op1} + {1'b0, r_op2} + {16'b0, w_cin});

    always_comb begin
        case (r_mode)
            OP_OR:   w_res = r_op1 | r_op2;
            OP_AND:  w_res = r_op1 & r_op2;
            OP_XOR:  w_res = r_op1 ^ r_op2;
            default: w_res = w_arith[15:0];
        endcase
    end

    assign w_res_sz = r_size ? w_res : {8'h00, w_res[7:0]};
    assign w_a_msb  = r_size ? r_op1[15] : r_op1[7];
    assign w_b_msb  = r_size ? r_op2[15] : r_op2[7];
    assign w_r_msb  = r_size ? w_res[15] : w_res[7];

    // Byte carry/borrow out of bit 7 is recovered from the bit-8 sum of the full-width result.
    always_comb begin
        w_flags     = r_flags_in;
        w_flags[0]  = w_is_logic ? 1'b0 : (r_size ? w_arith[16] : (r_op1[8] ^ r_op2[8] ^ w_arith[8]));
        w_flags[2]  = ~^w_res[7:0];
        w_flags[4]  = w_is_logic ? 1'b0 : (r_op1[4] ^ r_op2[4] ^ w_res[4]);
        w_flags[6]  = (w_res_sz == 16'h0000);
        w_flags[7]  = w_r_msb;
        w_flags[11] = w_is_logic ? 1'b0 :
                      (w_is_sub ? ((w_a_msb != w_b_msb) && (w_r_msb != w_a_msb))
                                : ((w_a_msb == w_b_msb) && (w_r_msb != w_a_msb)));
    end

    assign w_ea_inc  = r_ea + 16'd1;
    assign w_addr_lo = {r_seg, 4'h0} + {4'h0, r_ea};
    assign w_addr_hi = {r_seg, 4'h0} + {4'h0, w_ea_inc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_reg_we   <= 1'b0;
            r_bus_sel  <= 1'b0;
            r_wreq     <= 1'b0;
            r_reg_size <= 1'b0;
            r_reg_num  <= 3'd0;
            r_reg_data <= 16'h0000;
            r_mode     <= 3'd0;
            r_size     <= 1'b0;
            r_dir      <= 1'b0;
            r_modrm    <= 8'h00;
            r_op1      <= 16'h0000;
            r_op2      <= 16'h0000;
            r_seg      <= 16'h0000;
            r_ea       <= 16'h0000;
            r_res      <= 16'h0000;
            r_flags_in <= '0;
            r_flags    <= '0;
            r_address  <= 20'h00000;
            r_data     <= 8'h00;
        end else if (locked) begin
            r_done   <= 1'b0;
            r_reg_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy still covers the retire cycle of a register/CMP op, so a start there is dropped
                    if (start && !r_busy) begin
                        r_state    <= CALC;
                        r_busy     <= 1'b1;
                        r_mode     <= alumode;
                        r_size     <= isize;
                        r_dir      <= idir;
                        r_modrm    <= modrm;
                        r_op1      <= op1;
                        r_op2      <= op2;
                        r_flags_in <= flags_in;
                        r_seg      <= seg;
                        r_ea       <= ea;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                CALC: begin
                    r_flags <= w_flags;
                    r_res   <= w_res_sz;
                    if (r_mode == OP_CMP) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_to_reg) begin
                        r_reg_we   <= 1'b1;
                        r_done     <= 1'b1;
                        r_reg_num  <= r_dir ? r_modrm[5:3] : r_modrm[2:0];
                        r_reg_size <= r_size;
                        r_reg_data <= w_res_sz;
                        r_state    <= IDLE;
                    end else begin
                        r_state   <= WRLO;
                        r_bus_sel <= 1'b1;
                        r_wreq    <= 1'b1;
                        r_address <= w_addr_lo;
                        r_data    <= w_res[7:0];
                        r_done    <= ~r_size;
                    end
                end
                WRLO: begin
                    if (r_size) begin
                        r_state   <= WRHI;
                        r_address <= w_addr_hi;
                        r_data    <= r_res[15:8];
                        r_done    <= 1'b1;
                    end else begin
                        r_state   <= IDLE;
                        r_wreq    <= 1'b0;
                        r_bus_sel <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_wreq    <= 1'b0;
                    r_bus_sel <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign flags_out = r_flags;
    assign reg_we    = r_reg_we;
    assign reg_num   = r_reg_num;
    assign reg_size  = r_reg_size;
    assign reg_data  = r_reg_data;
    assign bus_sel   = r_bus_sel;
    assign address   = r_address;
    assign data      = r_data;
    assign wreq      = r_wreq;
endmodule
